// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the FPU issue controller.
// FpOp opcodes, issue FSM states, common widths.
package fpu_issue_ctrl_pkg;

  localparam int FP_ADDR_W   = 5;
  localparam int FP_DATA_W   = 32;
  localparam int FP_MAX_BUSY = 64;

  typedef logic                 Signal;
  typedef logic [FP_ADDR_W-1:0] RegAddr;
  typedef logic [FP_DATA_W-1:0] Register;

  localparam Signal ENABLE  = 1'b1;
  localparam Signal DISABLE = 1'b0;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_FADD   = 2'd1,
    OP_FLOAD  = 2'd2,
    OP_FSTORE = 2'd3
  } FpOp;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_BUSY   = 3'd3,
    S_STORE  = 3'd4,
    S_ST_OUT = 3'd5
  } FpIssueState;

endpackage

// File: rtl/fpu_issue_ctrl_timer.sv
// Busy watchdog: counts cycles of an FPU op.
// Ports: clk, rst, clr, en in; expire out.
module fpu_busy_timer #(
  parameter int MAX_BUSY = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(MAX_BUSY + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BUSY - 1);

  logic [CNT_W-1:0] busy_cnt;

  // Saturates at LAST; the FSM leaves on expire anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (clr) begin
      busy_cnt <= '0;
    end else if (en && busy_cnt != LAST) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  assign expire = en && (busy_cnt == LAST);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues FADD/FLOAD/FSTORE to the FPU wrapper.
// Ports: instr handshake in, FPU control/RF load out, store data out.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int ADDR_W   = FP_ADDR_W,
  parameter int DATA_W   = FP_DATA_W,
  parameter int MAX_BUSY = FP_MAX_BUSY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_fs,
  input  logic [ADDR_W-1:0] instr_ft,
  input  logic [ADDR_W-1:0] instr_fd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              mem_stall,
  input  logic              fpu_working,
  input  logic [DATA_W-1:0] fpu_ft,
  output logic              fpu_start,
  output logic              fpu_stall,
  output logic [ADDR_W-1:0] fpu_fs,
  output logic [ADDR_W-1:0] fpu_ft_addr,
  output logic [ADDR_W-1:0] fpu_fd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_write,
  output logic              st_valid,
  output logic [DATA_W-1:0] st_data,
  output logic              fpu_err
);

  FpIssueState state;
  FpOp         op;
  logic        accept;
  logic        fadd_go;
  logic        tmr_en;
  logic        expire;

  assign op        = FpOp'(instr_op);
  assign fpu_stall = mem_stall;

  assign instr_ready = ~rst & (state == S_IDLE) & ~mem_stall;
  assign accept      = instr_valid & instr_ready;
  assign fadd_go     = accept & (op == OP_FADD);

  assign tmr_en = (state == S_LAUNCH) |
                  (state == S_WAIT)   |
                  (state == S_BUSY);

  fpu_busy_timer #(
    .MAX_BUSY (MAX_BUSY)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (fadd_go),
    .en     (tmr_en),
    .expire (expire)
  );

  assign fpu_start = (state == S_LAUNCH);
  assign st_valid  = (state == S_ST_OUT);
  // fpu_ft is the FPU's registered RF read; pass through while valid.
  assign st_data   = st_valid ? fpu_ft : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fpu_fs      <= '0;
      fpu_ft_addr <= '0;
      fpu_fd      <= '0;
      m_addr      <= '0;
      m_data      <= '0;
      m_write     <= DISABLE;
      fpu_err     <= DISABLE;
    end else begin
      m_write <= DISABLE;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (op)
              OP_FADD: begin
                fpu_fs      <= instr_fs;
                fpu_ft_addr <= instr_ft;
                fpu_fd      <= instr_fd;
                state       <= S_LAUNCH;
              end
              OP_FLOAD: begin
                m_write <= ENABLE;
                m_addr  <= instr_fd;
                m_data  <= ld_data;
              end
              OP_FSTORE: begin
                fpu_ft_addr <= instr_ft;
                state       <= S_STORE;
              end
              OP_NOP: begin
              end
            endcase
          end
        end
        // FPU ignores start while stalled, so hold it.
        S_LAUNCH: begin
          if (expire) begin
            fpu_err <= ENABLE;
            state   <= S_IDLE;
          end else if (!mem_stall) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (expire) begin
            fpu_err <= ENABLE;
            state   <= S_IDLE;
          end else if (fpu_working) begin
            state <= S_BUSY;
          end
        end
        // A normal finish wins over a same-cycle timeout.
        S_BUSY: begin
          if (!fpu_working) begin
            state <= S_IDLE;
          end else if (expire) begin
            fpu_err <= ENABLE;
            state   <= S_IDLE;
          end
        end
        S_STORE: begin
          state <= S_ST_OUT;
        end
        S_ST_OUT: begin
          if (!mem_stall) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl.
// Small FPU RF model with registered ft read.
module tb_fpu_issue_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_fs;
  logic [AW-1:0] instr_ft;
  logic [AW-1:0] instr_fd;
  logic [DW-1:0] ld_data;
  logic          mem_stall;
  logic          fpu_working;
  logic [DW-1:0] fpu_ft;
  logic          fpu_start;
  logic          fpu_stall;
  logic [AW-1:0] fpu_fs;
  logic [AW-1:0] fpu_ft_addr;
  logic [AW-1:0] fpu_fd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_write;
  logic          st_valid;
  logic [DW-1:0] st_data;
  logic          fpu_err;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BUSY (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_fs    (instr_fs),
    .instr_ft    (instr_ft),
    .instr_fd    (instr_fd),
    .ld_data     (ld_data),
    .mem_stall   (mem_stall),
    .fpu_working (fpu_working),
    .fpu_ft      (fpu_ft),
    .fpu_start   (fpu_start),
    .fpu_stall   (fpu_stall),
    .fpu_fs      (fpu_fs),
    .fpu_ft_addr (fpu_ft_addr),
    .fpu_fd      (fpu_fd),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_write     (m_write),
    .st_valid    (st_valid),
    .st_data     (st_data),
    .fpu_err     (fpu_err)
  );

  always @(posedge clk) begin
    if (m_write) rf[m_addr] <= m_data;
    fpu_ft <= rf[fpu_ft_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [AW-1:0] fs,
                       input logic [AW-1:0] ft,
                       input logic [AW-1:0] fd,
                       input logic [DW-1:0] d);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_fs    = fs;
    instr_ft    = ft;
    instr_fd    = fd;
    ld_data     = d;
  endtask

  task automatic idle_in();
    instr_valid = 1'b0;
    instr_op    = 2'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    fpu_ft      = '0;
    rst         = 1'b1;
    mem_stall   = 1'b0;
    fpu_working = 1'b0;
    instr_fs    = '0;
    instr_ft    = '0;
    instr_fd    = '0;
    ld_data     = '0;
    idle_in();
    tick();
    tick();
    settle();
    chk("rst_ready", instr_ready, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_mw", m_write, 0);
    chk("rst_stv", st_valid, 0);
    chk("rst_err", fpu_err, 0);
    rst = 1'b0;
    tick();

    // Back-to-back FLOADs
    issue(2'd2, 0, 0, 3, 32'h3F80_0000);
    settle();
    chk("ld1_ready", instr_ready, 1);
    tick();
    issue(2'd2, 0, 0, 4, 32'h4000_0000);
    settle();
    chk("ld1_mw", m_write, 1);
    chk("ld1_addr", m_addr, 3);
    chk("ld1_data", m_data, 32'h3F80_0000);
    chk("ld2_ready", instr_ready, 1);
    tick();
    idle_in();
    settle();
    chk("ld2_mw", m_write, 1);
    chk("ld2_addr", m_addr, 4);
    chk("ld2_data", m_data, 32'h4000_0000);
    tick();
    settle();
    chk("ld_end_mw", m_write, 0);

    // FADD 3,4 -> 5 with working from T+2 to T+5
    issue(2'd1, 3, 4, 5, 0);
    settle();
    chk("fadd_T_start", fpu_start, 0);
    tick();
    idle_in();
    settle();
    chk("fadd_T1_start", fpu_start, 1);
    chk("fadd_T1_ready", instr_ready, 0);
    chk("fadd_T1_fs", fpu_fs, 3);
    tick();
    fpu_working = 1'b1;
    settle();
    chk("fadd_T2_start", fpu_start, 0);
    chk("fadd_T2_ft", fpu_ft_addr, 4);
    for (int k = 3; k <= 5; k++) begin
      tick();
      settle();
      chk("fadd_busy_ready", instr_ready, 0);
      chk("fadd_busy_fd", fpu_fd, 5);
    end
    tick();
    fpu_working = 1'b0;
    settle();
    chk("fadd_T6_ready", instr_ready, 0);
    chk("fadd_T6_fs", fpu_fs, 3);
    chk("fadd_T6_ft", fpu_ft_addr, 4);
    chk("fadd_T6_fd", fpu_fd, 5);
    tick();
    settle();
    chk("fadd_T7_ready", instr_ready, 1);
    chk("fadd_T7_err", fpu_err, 0);

    // FLOAD r5 then FSTORE r5 right behind it
    issue(2'd2, 0, 0, 5, 32'h4040_0000);
    tick();
    issue(2'd3, 0, 5, 0, 0);
    settle();
    chk("st_T_stv", st_valid, 0);
    tick();
    idle_in();
    settle();
    chk("st_T1_addr", fpu_ft_addr, 5);
    chk("st_T1_stv", st_valid, 0);
    tick();
    settle();
    chk("st_T2_stv", st_valid, 1);
    chk("st_T2_data", st_data, 32'h4040_0000);
    tick();
    settle();
    chk("st_T3_stv", st_valid, 0);
    chk("st_T3_ready", instr_ready, 1);

    // Stall during LAUNCH for 3 cycles
    issue(2'd1, 1, 2, 6, 0);
    tick();
    idle_in();
    mem_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk("stl_start", fpu_start, 1);
      chk("stl_fstall", fpu_stall, 1);
      tick();
    end
    mem_stall = 1'b0;
    settle();
    chk("stl_T4_start", fpu_start, 1);
    chk("stl_T4_fstall", fpu_stall, 0);
    tick();
    fpu_working = 1'b1;
    settle();
    chk("stl_T5_start", fpu_start, 0);
    chk("stl_T5_ready", instr_ready, 0);
    tick();
    fpu_working = 1'b0;
    settle();
    chk("stl_T6_ready", instr_ready, 0);
    tick();
    settle();
    chk("stl_T7_ready", instr_ready, 1);

    // Hung FPU: timeout with MAX_BUSY=8
    issue(2'd1, 1, 2, 7, 0);
    tick();
    idle_in();
    tick();
    fpu_working = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      tick();
      settle();
      chk("to_wait_err", fpu_err, 0);
      chk("to_wait_ready", instr_ready, 0);
    end
    tick();
    settle();
    chk("to_T9_err", fpu_err, 1);
    chk("to_T9_ready", instr_ready, 1);
    issue(2'd2, 0, 0, 7, 32'h0000_00AA);
    tick();
    idle_in();
    settle();
    chk("to_ld_mw", m_write, 1);
    chk("to_ld_addr", m_addr, 7);
    chk("to_sticky", fpu_err, 1);
    fpu_working = 1'b0;
    tick();
    settle();
    chk("to_sticky2", fpu_err, 1);

    // Reset while BUSY
    issue(2'd1, 3, 4, 5, 0);
    tick();
    idle_in();
    tick();
    fpu_working = 1'b1;
    tick();
    settle();
    chk("rb_busy_ready", instr_ready, 0);
    rst = 1'b1;
    tick();
    settle();
    chk("rb_ready", instr_ready, 0);
    chk("rb_start", fpu_start, 0);
    chk("rb_err", fpu_err, 0);
    chk("rb_fs", fpu_fs, 0);
    chk("rb_ft", fpu_ft_addr, 0);
    chk("rb_fd", fpu_fd, 0);
    chk("rb_maddr", m_addr, 0);
    chk("rb_mdata", m_data, 0);
    chk("rb_mw", m_write, 0);
    chk("rb_stv", st_valid, 0);
    chk("rb_std", st_data, 0);
    rst = 1'b0;
    fpu_working = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      chk("rb_after_stv", st_valid, 0);
      chk("rb_after_mw", m_write, 0);
      chk("rb_after_start", fpu_start, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Pipeline-side initiator that drives the FPU wrapper.
- Accepts decoded FP instructions (FADD, FLOAD, FSTORE) over a valid/ready handshake.
- Sequences FPU start and register addresses, drives the FPU register-file load port, and returns FSTORE data to the memory stage.
- Serialises FPU use and times out a hung FPU.

Parameters:
- ADDR_W, 5: FP register address width (RegAddr).
- DATA_W, 32: FP data width (Register).
- MAX_BUSY, 64: cycles allowed from LAUNCH until fpu_working falls before error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  decoded FP instruction present
- instr_ready  out  1  instruction accepted this cycle when valid&ready
- instr_op  in  2  FpOp: NOP=0, FADD=1, FLOAD=2, FSTORE=3
- instr_fs  in  ADDR_W  FADD source a
- instr_ft  in  ADDR_W  FADD source b / FSTORE source
- instr_fd  in  ADDR_W  FADD dest / FLOAD dest
- ld_data  in  DATA_W  FLOAD data, valid with instr_valid
- mem_stall  in  1  downstream stall
- fpu_working  in  1  FPU working
- fpu_ft  in  DATA_W  FPU out.ft, registered RF read of ft addr
- fpu_start  out  1  FPU start
- fpu_stall  out  1  FPU stall
- fpu_fs, fpu_ft_addr, fpu_fd  out  ADDR_W  FPU register addresses
- m_addr  out  ADDR_W  FPU RF load address
- m_data  out  DATA_W  FPU RF load data
- m_write  out  1  FPU RF load strobe
- st_valid  out  1  store data valid, one-cycle pulse
- st_data  out  DATA_W  store data
- fpu_err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: instr_ready, fpu_start, m_write, st_valid, fpu_err, addresses and data.
  - Reset mid-operation abandons any in-flight op; no pulse is emitted afterwards.
- fpu_stall = mem_stall (combinational).
- instr_ready = (state==IDLE) & ~mem_stall.
- Accept = instr_valid & instr_ready. NOP is accepted with no effect.
- FSM states: IDLE, LAUNCH, WAIT, BUSY, STORE, ST_OUT.
- IDLE:
  - Accept FADD: register fs/ft/fd into fpu_fs/fpu_ft_addr/fpu_fd, go to LAUNCH.
  - Accept FLOAD: next cycle m_write=1 for exactly 1 cycle, m_addr=fd, m_data=ld_data. Stay IDLE, so back-to-back FLOADs give one write per cycle.
  - Accept FSTORE: register ft into fpu_ft_addr, go to STORE.
- LAUNCH:
  - fpu_start=1.
  - If mem_stall, hold LAUNCH (FPU ignores start while stalled). Otherwise go to WAIT.
- WAIT:
  - fpu_working=1 -> BUSY.
  - Otherwise remain in WAIT.
- BUSY:
  - fpu_working=0 -> IDLE.
- Address hold: fpu_fs/fpu_ft_addr/fpu_fd stay stable from LAUNCH until re-entry to IDLE. The FPU samples operands and bypasses against them one cycle after start.
- Timeout:
  - busy_cnt clears on entry to LAUNCH and increments each cycle in LAUNCH/WAIT/BUSY.
  - When busy_cnt reaches MAX_BUSY-1 and the FSM is not exiting: set fpu_err (sticky until rst) and go to IDLE.
- STORE: one cycle, fpu_ft_addr driven; go to ST_OUT.
- ST_OUT:
  - st_valid=1 and st_data=fpu_ft (combinational) for 1 cycle.
  - Then IDLE, unless mem_stall, in which case hold ST_OUT with st_data stable.
- Ordering:
  - FLOAD followed by FSTORE or FADD on the same register needs no interlock: the RF write lands at least 1 cycle before the read.
  - FADD writeback and FLOAD never coincide, because FLOAD is only accepted in IDLE.
- FSTORE after FADD writing the same register: the FADD result is committed before IDLE, so FSTORE reads the new value.

Decomposition:
- Shared package (definitions): FpOp enum, FpIssueState enum, FP_MAX_BUSY default. Reuse RegAddr, Register, Signal, ENABLE/DISABLE.
- Natural sub-module: fpu_busy_timer (busy_cnt with clear/enable/expire). FSM and datapath stay in the top module.

Test Plan:
- FLOAD fd=3, ld_data=32'h3F80_0000, then FLOAD fd=4, ld_data=32'h4000_0000 on consecutive cycles -> m_write pulses on 2 consecutive cycles: (3,3F800000), then (4,40000000). instr_ready stays 1.
- FADD fs=3 ft=4 fd=5 accepted at T -> fpu_start=1 only at T+1. Model raises working at T+2 and drops it at T+6. Addresses remain 3/4/5 through T+6, instr_ready=0 from T+1 to T+6, FSM is IDLE at T+7.
- FSTORE ft=5 with model RF[5]=32'h4040_0000 -> fpu_ft_addr=5 at T+1, st_valid=1 with st_data=40400000 at T+2, single pulse.
- mem_stall=1 during LAUNCH for 3 cycles -> fpu_start stays high for 4 cycles and fpu_stall mirrors mem_stall. No BUSY entry until the stall releases.
- MAX_BUSY=8, model holds fpu_working=1 forever after FADD -> fpu_err=1 at the 8th cycle after entering LAUNCH, then IDLE. A following FLOAD is accepted and fpu_err stays 1 until rst.
- rst asserted while in BUSY -> next cycle state=IDLE and all outputs 0, including fpu_err. No st_valid or m_write follows.
